layer_compositor: RTL and testbench

//  Parametrised, pipelined pixel compositor for the game display path. Merges N priority

---
 rtl/layer_compositor.sv | 183 ++++++++++++++++++
 tb/tb_layer_compositor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: priority layer select, fade scaling, sync delay matching, fade FSM.
// Define SAT_BLEND_EN to saturate the floor+overlay blend per channel instead of wrapping mod 16.
module layer_compositor #(
  parameter int          N_LAYERS    = 4,
  parameter int          N_OVERLAY   = 4,
  parameter logic [11:0] TRANSP      = 12'hFFF,
  parameter int          FADE_STEPS  = 16,
  parameter int          STEP_FRAMES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_LAYERS*12-1:0]  layer_pixels,
  input  logic [N_LAYERS-1:0]     layer_en,
  input  logic [11:0]             object_pixel,
  input  logic                    object_valid,
  input  logic [11:0]             floor_pixel,
  input  logic [N_OVERLAY*12-1:0] overlay_pixels,
  input  logic [11:0]             screen_pixel,
  input  logic [2:0]              game_state,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic                    blank,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    blank_out,
  output logic [11:0]             pixel_out,
  output logic [2:0]              shown_state,
  output logic                    fade_busy
);

  localparam int LW    = $clog2(FADE_STEPS) + 1;
  localparam int SHIFT = $clog2(FADE_STEPS);
  localparam int PW    = 4 + LW;
  localparam int SW    = 4 + $clog2(N_OVERLAY + 1);
  localparam int FW    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [LW-1:0] LEVEL_MAX  = LW'(FADE_STEPS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(STEP_FRAMES - 1);
  localparam logic [2:0]    WELCOME    = 3'd0;

  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} fade_state_t;

  fade_state_t   state, state_next;
  logic [LW-1:0] level, level_next;
  logic [2:0]    target, target_next, shown_next;
  logic [FW-1:0] frame_cnt, frame_next;
  logic          vsync_prev, tick, step;

  logic [11:0]   blend, select_pix, stage1_pix, scaled;
  logic [SW-1:0] chan_sum;
  logic [PW-1:0] chan_prod;
  logic          blank_d1, hsync_d1, vsync_d1;

  // Sum is kept wide enough for every overlay so the saturating build sees the true total.
  always_comb begin
    blend    = '0;
    chan_sum = '0;
    for (int ch = 0; ch < 3; ch++) begin
      chan_sum = SW'(floor_pixel[ch*4 +: 4]);
      for (int o = 0; o < N_OVERLAY; o++)
        chan_sum = chan_sum + SW'(overlay_pixels[o*12 + ch*4 +: 4]);
`ifdef SAT_BLEND_EN
      blend[ch*4 +: 4] = (chan_sum > SW'(15)) ? 4'hF : chan_sum[3:0];
`else
      blend[ch*4 +: 4] = chan_sum[3:0];
`endif
    end
  end

  // Lowest-priority candidates are assigned first so later hits override them.
  always_comb begin
    select_pix = blend;
    if (object_valid && object_pixel != TRANSP)
      select_pix = object_pixel;
    for (int i = N_LAYERS - 1; i >= 0; i--)
      if (layer_en[i] && layer_pixels[i*12 +: 12] != TRANSP)
        select_pix = layer_pixels[i*12 +: 12];
    if (shown_state == WELCOME && screen_pixel != 12'h000)
      select_pix = screen_pixel;
  end

  always_comb begin
    scaled    = '0;
    chan_prod = '0;
    for (int ch = 0; ch < 3; ch++) begin
      chan_prod = PW'(stage1_pix[ch*4 +: 4]) * PW'(level);
      scaled[ch*4 +: 4] = chan_prod[SHIFT +: 4];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage1_pix <= '0;
      blank_d1   <= 1'b0;
      hsync_d1   <= 1'b1;
      vsync_d1   <= 1'b1;
      pixel_out  <= '0;
      blank_out  <= 1'b0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
    end else begin
      stage1_pix <= select_pix;
      blank_d1   <= blank;
      hsync_d1   <= hsync;
      vsync_d1   <= vsync;
      pixel_out  <= blank_d1 ? 12'h000 : scaled;
      blank_out  <= blank_d1;
      hsync_out  <= hsync_d1;
      vsync_out  <= vsync_d1;
    end
  end

  assign tick      = vsync_prev & ~vsync;
  assign step      = tick && (frame_cnt == FRAME_LAST);
  assign fade_busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      level       <= LEVEL_MAX;
      target      <= WELCOME;
      shown_state <= WELCOME;
      frame_cnt   <= '0;
      vsync_prev  <= 1'b1;
    end else begin
      state       <= state_next;
      level       <= level_next;
      target      <= target_next;
      shown_state <= shown_next;
      frame_cnt   <= frame_next;
      vsync_prev  <= vsync;
    end
  end

  // A change during FADE_IN has priority over that cycle's step so the fade reverses from the current level.
  always_comb begin
    state_next  = state;
    level_next  = level;
    target_next = target;
    shown_next  = shown_state;
    frame_next  = frame_cnt;
    if (tick)
      frame_next = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
    case (state)
      IDLE: begin
        frame_next = '0;
        if (game_state != shown_state) begin
          target_next = game_state;
          state_next  = FADE_OUT;
        end
      end
      FADE_OUT: begin
        target_next = game_state;
        if (level == '0)
          state_next = SWAP;
        else if (step) begin
          level_next = level - 1'b1;
          if (level == LW'(1))
            state_next = SWAP;
        end
      end
      SWAP: begin
        if (tick) begin
          shown_next = target;
          state_next = FADE_IN;
        end
      end
      FADE_IN: begin
        if (game_state != target) begin
          target_next = game_state;
          state_next  = FADE_OUT;
        end else if (level == LEVEL_MAX)
          state_next = IDLE;
        else if (step) begin
          level_next = level + 1'b1;
          if (level == LEVEL_MAX - 1'b1)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised bench for layer_compositor: behavioural reference model plus directed literal checks.
module tb_layer_compositor;

  localparam int          N_LAYERS    = 4;
  localparam int          N_OVERLAY   = 4;
  localparam logic [11:0] TRANSP      = 12'hFFF;
  localparam int          FADE_STEPS  = 16;
  localparam int          STEP_FRAMES = 1;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [N_LAYERS*12-1:0]  layer_pixels;
  logic [N_LAYERS-1:0]     layer_en;
  logic [11:0]             object_pixel;
  logic                    object_valid;
  logic [11:0]             floor_pixel;
  logic [N_OVERLAY*12-1:0] overlay_pixels;
  logic [11:0]             screen_pixel;
  logic [2:0]              game_state;
  logic                    hsync, vsync, blank;
  logic                    hsync_out, vsync_out, blank_out;
  logic [11:0]             pixel_out;
  logic [2:0]              shown_state;
  logic                    fade_busy;

  always #5 clock = ~clock;

  layer_compositor #(
    .N_LAYERS(N_LAYERS), .N_OVERLAY(N_OVERLAY), .TRANSP(TRANSP),
    .FADE_STEPS(FADE_STEPS), .STEP_FRAMES(STEP_FRAMES)
  ) dut (
    .clock(clock), .reset(reset),
    .layer_pixels(layer_pixels), .layer_en(layer_en),
    .object_pixel(object_pixel), .object_valid(object_valid),
    .floor_pixel(floor_pixel), .overlay_pixels(overlay_pixels),
    .screen_pixel(screen_pixel), .game_state(game_state),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .pixel_out(pixel_out), .shown_state(shown_state), .fade_busy(fade_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: what the screen should show, tracked as plain integers.
  int          m_shown, m_target, m_level, m_phase, m_frames;
  bit          m_prev_vs;
  logic [11:0] s1_pix, exp_pix;
  bit          s1_blank, s1_hs, s1_vs, exp_blank, exp_hs, exp_vs;

  function automatic logic [11:0] model_select(input int shown);
    logic [11:0] res;
    int s;
    if (shown == 0 && screen_pixel != 12'h000) return screen_pixel;
    for (int i = 0; i < N_LAYERS; i++)
      if (layer_en[i] && layer_pixels[i*12 +: 12] != TRANSP) return layer_pixels[i*12 +: 12];
    if (object_valid && object_pixel != TRANSP) return object_pixel;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(floor_pixel[ch*4 +: 4]);
      for (int o = 0; o < N_OVERLAY; o++) s += int'(overlay_pixels[o*12 + ch*4 +: 4]);
`ifdef SAT_BLEND_EN
      if (s > 15) s = 15;
`else
      s = s % 16;
`endif
      res[ch*4 +: 4] = 4'(s);
    end
    return res;
  endfunction

  function automatic logic [11:0] model_scale(input logic [11:0] p, input int lvl);
    logic [11:0] res;
    int c;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c = int'(p[ch*4 +: 4]);
      res[ch*4 +: 4] = 4'((c * lvl) / FADE_STEPS);
    end
    return res;
  endfunction

  task automatic model_reset();
    m_shown = 0; m_target = 0; m_level = FADE_STEPS; m_phase = 0; m_frames = 0; m_prev_vs = 1'b1;
    s1_pix = '0; s1_blank = 1'b0; s1_hs = 1'b1; s1_vs = 1'b1;
    exp_pix = '0; exp_blank = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
  endtask

  task automatic model_step();
    bit tk, stp;
    tk = m_prev_vs && !vsync;
    m_prev_vs = vsync;
    stp = tk && (m_frames + 1 == STEP_FRAMES);
    exp_pix   = s1_blank ? 12'h000 : model_scale(s1_pix, m_level);
    exp_blank = s1_blank; exp_hs = s1_hs; exp_vs = s1_vs;
    s1_pix    = model_select(m_shown);
    s1_blank  = blank; s1_hs = hsync; s1_vs = vsync;
    if (m_phase == 0) m_frames = 0;
    else if (tk) m_frames = stp ? 0 : m_frames + 1;
    case (m_phase)
      0: if (int'(game_state) != m_shown) begin m_target = game_state; m_phase = 1; end
      1: begin
        m_target = game_state;
        if (m_level == 0) m_phase = 2;
        else if (stp) begin
          m_level--;
          if (m_level == 0) m_phase = 2;
        end
      end
      2: if (tk) begin m_shown = m_target; m_phase = 3; end
      default: begin
        if (int'(game_state) != m_target) begin m_target = game_state; m_phase = 1; end
        else if (stp) begin
          m_level++;
          if (m_level == FADE_STEPS) m_phase = 0;
        end
      end
    endcase
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    if (reset) begin
      checkOutput("pixel_out", pixel_out, exp_pix);
      checkOutput("hsync_out", 12'(hsync_out), 12'(exp_hs));
      checkOutput("vsync_out", 12'(vsync_out), 12'(exp_vs));
      checkOutput("blank_out", 12'(blank_out), 12'(exp_blank));
      checkOutput("shown_state", 12'(shown_state), 12'(m_shown));
      checkOutput("fade_busy", 12'(fade_busy), 12'(m_phase != 0));
    end
  end

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic run_frame(input int low_c, input int high_c);
    vsync = 1'b0;
    repeat (low_c) next_cycle();
    vsync = 1'b1;
    repeat (high_c) next_cycle();
  endtask

  task automatic set_flat(input logic [11:0] fl);
    layer_en = '0; layer_pixels = '0; object_valid = 1'b0; object_pixel = '0;
    screen_pixel = '0; overlay_pixels = '0; floor_pixel = fl; blank = 1'b0; hsync = 1'b1;
  endtask

  function automatic logic [11:0] rand_px();
    case ($urandom_range(0, 3))
      0: return 12'hFFF;
      1: return 12'h000;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < N_LAYERS; i++) layer_pixels[i*12 +: 12] = rand_px();
    for (int o = 0; o < N_OVERLAY; o++)
      overlay_pixels[o*12 +: 12] = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
    layer_en     = 4'($urandom);
    object_pixel = rand_px();
    object_valid = 1'($urandom);
    floor_pixel  = 12'($urandom);
    screen_pixel = ($urandom_range(0, 1) == 0) ? 12'h000 : rand_px();
    blank        = ($urandom_range(0, 7) == 0);
    hsync        = ($urandom_range(0, 15) != 0);
    if ($urandom_range(0, 399) == 0) game_state = 3'($urandom_range(0, 4));
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_pixel"}, pixel_out, 12'h000);
    checkOutput({tag, "_hsync"}, 12'(hsync_out), 12'h001);
    checkOutput({tag, "_vsync"}, 12'(vsync_out), 12'h001);
    checkOutput({tag, "_blank"}, 12'(blank_out), 12'h000);
    checkOutput({tag, "_busy"}, 12'(fade_busy), 12'h000);
    checkOutput({tag, "_shown"}, 12'(shown_state), 12'h000);
  endtask

  initial begin
    game_state = 3'd0; vsync = 1'b1;
    set_flat(12'hFFF);
    repeat (3) next_cycle();
    check_reset_values("init_reset");
    reset = 1'b1;
    next_cycle();

    // Fade WELCOME -> PLAY on a flat white pixel.
    game_state = 3'd2;
    next_cycle();
    repeat (8) run_frame(2, 6);
    checkOutput("fade8_pixel", pixel_out, 12'h777);
    checkOutput("fade8_busy", 12'(fade_busy), 12'h001);
    repeat (8) run_frame(2, 6);
    checkOutput("fade16_pixel", pixel_out, 12'h000);
    checkOutput("fade16_shown", 12'(shown_state), 12'h000);
    run_frame(2, 6);
    checkOutput("fade17_shown", 12'(shown_state), 12'h002);
    repeat (15) run_frame(2, 6);
    checkOutput("fade32_pixel", pixel_out, 12'hEEE);
    checkOutput("fade32_busy", 12'(fade_busy), 12'h001);
    run_frame(2, 6);
    checkOutput("fade33_busy", 12'(fade_busy), 12'h000);
    checkOutput("fade33_pixel", pixel_out, 12'hFFF);

    // Layer priority over the object.
    layer_en = 4'b0011;
    layer_pixels = {12'h123, 12'h456, 12'h0F0, 12'hFFF};
    object_valid = 1'b1; object_pixel = 12'h00F;
    repeat (2) next_cycle();
    checkOutput("prio_pixel", pixel_out, 12'h0F0);

    // Floor plus overlays.
    layer_en = 4'b1111;
    layer_pixels = {4{12'hFFF}};
    object_valid = 1'b0;
    floor_pixel = 12'h888;
    overlay_pixels = {12'h000, 12'h000, 12'h00A, 12'h008};
    repeat (2) next_cycle();
`ifdef SAT_BLEND_EN
    checkOutput("blend_pixel", pixel_out, 12'h88F);
`else
    checkOutput("blend_pixel", pixel_out, 12'h88A);
`endif

    // Sync alignment: one-cycle blank/hsync/vsync pulse appears two cycles later.
    set_flat(12'h5A5);
    repeat (2) next_cycle();
    blank = 1'b1; hsync = 1'b0; vsync = 1'b0;
    next_cycle();
    checkOutput("align_n1_blank", 12'(blank_out), 12'h000);
    checkOutput("align_n1_hsync", 12'(hsync_out), 12'h001);
    blank = 1'b0; hsync = 1'b1; vsync = 1'b1;
    next_cycle();
    checkOutput("align_n2_blank", 12'(blank_out), 12'h001);
    checkOutput("align_n2_pixel", pixel_out, 12'h000);
    checkOutput("align_n2_hsync", 12'(hsync_out), 12'h000);
    checkOutput("align_n2_vsync", 12'(vsync_out), 12'h000);
    next_cycle();
    checkOutput("align_n3_blank", 12'(blank_out), 12'h000);
    checkOutput("align_n3_vsync", 12'(vsync_out), 12'h001);
    checkOutput("align_n3_pixel", pixel_out, 12'h5A5);

    // Retarget during FADE_IN at level 10.
    set_flat(12'hFFF);
    game_state = 3'd3;
    next_cycle();
    repeat (17) run_frame(1, 5);
    checkOutput("refade_shown3", 12'(shown_state), 12'h003);
    repeat (10) run_frame(1, 5);
    checkOutput("refade_l10_pixel", pixel_out, 12'h999);
    game_state = 3'd4;
    next_cycle();
    run_frame(1, 5);
    checkOutput("refade_l9_pixel", pixel_out, 12'h888);
    checkOutput("refade_l9_busy", 12'(fade_busy), 12'h001);
    repeat (9) run_frame(1, 5);
    checkOutput("refade_l0_pixel", pixel_out, 12'h000);
    checkOutput("refade_l0_shown", 12'(shown_state), 12'h003);
    repeat (17) run_frame(1, 5);
    checkOutput("refade_end_shown", 12'(shown_state), 12'h004);
    checkOutput("refade_end_busy", 12'(fade_busy), 12'h000);
    checkOutput("refade_end_pixel", pixel_out, 12'hFFF);

    // Randomised frames with occasional state changes and one reset mid-fade.
    for (int f = 0; f < 600; f++) begin
      if (f == 300) begin
        game_state = 3'((m_shown + 1) % 5);
        next_cycle();
        repeat (3) run_frame(1, 4);
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (3) next_cycle();
        reset = 1'b1;
      end
      vsync = 1'b0;
      repeat ($urandom_range(1, 3)) begin applyStimulus(); next_cycle(); end
      vsync = 1'b1;
      repeat ($urandom_range(3, 40)) begin applyStimulus(); next_cycle(); end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
